// File: rtl/btb_pkg.sv
// Shared BTB definitions: address width, index/tag split, prediction entry and outcome class.
// Used by the resolve unit, its prediction queue and the BTB itself.
package btb_pkg;

  localparam int ADDR_W  = 32;
  localparam int IDX_LSB = 2;
  localparam int IDX_MSB = 11;
  localparam int TAG_LSB = 12;
  localparam int TAG_MSB = 31;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              valid;
    logic [ADDR_W-1:0] target;
  } pred_entry_t;

  typedef enum logic [1:0] {
    CORRECT   = 2'd0,
    MISS_NT_T = 2'd1,
    MISS_TGT  = 2'd2,
    MISS_T_NT = 2'd3
  } outcome_t;

  function automatic outcome_t classify(input pred_entry_t p, input logic taken,
                                        input logic [ADDR_W-1:0] target);
    outcome_t o;
    o = CORRECT;
    if (p.valid) begin
      if (!taken)                o = MISS_T_NT;
      else if (target != p.target) o = MISS_TGT;
    end else if (taken) begin
      o = MISS_NT_T;
    end
    return o;
  endfunction

endpackage

// File: rtl/btb_resolve_unit_if.sv
// Fetch/execute/BTB-update signal bundle of the resolve unit.
// unit = the resolve unit's view, master = the surrounding pipeline's view.
interface btb_resolve_unit_if;
  import btb_pkg::*;

  logic              Pred_push_IN;
  logic [ADDR_W-1:0] Pred_PC_IN;
  logic              Pred_valid_IN;
  logic [ADDR_W-1:0] Pred_target_IN;
  logic              Full_OUT;
  logic              Resolve_IN;
  logic              Actual_taken_IN;
  logic [ADDR_W-1:0] Actual_target_IN;
  logic              Resolution_OUT;
  logic [ADDR_W-1:0] Branch_addr_OUT;
  logic [ADDR_W-1:0] Branch_resolved_addr_OUT;
  logic              Mispredict_OUT;
  logic [ADDR_W-1:0] Redirect_addr_OUT;
  logic              Underflow_OUT;
  logic [31:0]       Branch_count_OUT;
  logic [31:0]       Mispredict_count_OUT;

  modport unit (
    input  Pred_push_IN, Pred_PC_IN, Pred_valid_IN, Pred_target_IN,
    input  Resolve_IN, Actual_taken_IN, Actual_target_IN,
    output Full_OUT, Resolution_OUT, Branch_addr_OUT, Branch_resolved_addr_OUT,
    output Mispredict_OUT, Redirect_addr_OUT, Underflow_OUT,
    output Branch_count_OUT, Mispredict_count_OUT
  );

  modport master (
    output Pred_push_IN, Pred_PC_IN, Pred_valid_IN, Pred_target_IN,
    output Resolve_IN, Actual_taken_IN, Actual_target_IN,
    input  Full_OUT, Resolution_OUT, Branch_addr_OUT, Branch_resolved_addr_OUT,
    input  Mispredict_OUT, Redirect_addr_OUT, Underflow_OUT,
    input  Branch_count_OUT, Mispredict_count_OUT
  );

endinterface

// File: rtl/btb_resolve_unit_pred_fifo.sv
// In-order prediction queue: head visible combinationally, push/pop take effect next cycle.
// A push while full is dropped; flush empties the queue and also drops a same-cycle push.
module pred_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  pred_entry_t   push_entry,
  input  logic          pop,
  input  logic          flush,
  output pred_entry_t   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  pred_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Everything behind the resolved entry is wrong-path work.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btb_resolve_unit.sv
// Resolves queued BTB predictions against execute outcomes; drives BTB write-back, redirect, stats.
// Outputs registered one cycle after Resolve_IN; fetch must honour Full_OUT (pushes while full are lost).
module btb_resolve_unit
  import btb_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int FALLTHRU_OFFSET = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  btb_resolve_unit_if.unit  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  pred_entry_t   push_entry;
  pred_entry_t   head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          resolve_ok;
  logic          mispredict;
  logic          write_btb;
  outcome_t      outcome;

  logic              resolution_q;
  logic [ADDR_W-1:0] branch_addr_q;
  logic [ADDR_W-1:0] resolved_addr_q;
  logic              mispredict_q;
  logic [ADDR_W-1:0] redirect_q;
  logic              underflow_q;
  logic [31:0]       branch_cnt_q;
  logic [31:0]       mispredict_cnt_q;

  assign push_entry.pc     = bus.Pred_PC_IN;
  assign push_entry.valid  = bus.Pred_valid_IN;
  assign push_entry.target = bus.Pred_valid_IN ? bus.Pred_target_IN : '0;

  pred_fifo #(.DEPTH(DEPTH)) u_pred_fifo (
    .clk        (CLK),
    .rst_n      (RESET),
    .push       (bus.Pred_push_IN),
    .push_entry (push_entry),
    .pop        (resolve_ok),
    .flush      (mispredict),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign resolve_ok = bus.Resolve_IN && !empty;
  assign outcome    = classify(head, bus.Actual_taken_IN, bus.Actual_target_IN);
  assign mispredict = resolve_ok && (outcome != CORRECT);
  // A zero target means "no write" to the BTB, so it can never be installed.
  assign write_btb  = resolve_ok && (outcome == MISS_NT_T || outcome == MISS_TGT)
                      && (bus.Actual_target_IN != '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      resolution_q     <= 1'b0;
      branch_addr_q    <= '0;
      resolved_addr_q  <= '0;
      mispredict_q     <= 1'b0;
      redirect_q       <= '0;
      underflow_q      <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      resolution_q <= write_btb;
      mispredict_q <= mispredict;
      if (bus.Resolve_IN && empty) underflow_q <= 1'b1;
      if (resolve_ok) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (write_btb) begin
        branch_addr_q   <= head.pc;
        resolved_addr_q <= bus.Actual_target_IN;
      end
      if (mispredict) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        redirect_q       <= (outcome == MISS_T_NT) ? head.pc + ADDR_W'(FALLTHRU_OFFSET)
                                                   : bus.Actual_target_IN;
      end
    end
  end

  assign bus.Full_OUT                 = full;
  assign bus.Resolution_OUT           = resolution_q;
  assign bus.Branch_addr_OUT          = branch_addr_q;
  assign bus.Branch_resolved_addr_OUT = resolved_addr_q;
  assign bus.Mispredict_OUT           = mispredict_q;
  assign bus.Redirect_addr_OUT        = redirect_q;
  assign bus.Underflow_OUT            = underflow_q;
  assign bus.Branch_count_OUT         = branch_cnt_q;
  assign bus.Mispredict_count_OUT     = mispredict_cnt_q;

endmodule

// File: doc/btb_resolve_unit.md
Name: btb_resolve_unit

Overview:
- Resolution side of the branch-target-buffer protocol.
- Fetch pushes each BTB prediction into an in-order queue. Execute later resolves the oldest entry with the actual outcome.
- The unit compares prediction against outcome and generates the BTB write-back (Resolution/Branch_addr/Branch_resolved_addr), the pipeline redirect, and statistics counters.
- Sits between the fetch stage (BTB consumer) and the execute stage (branch ALU), driving the BTB update inputs.

Parameters:
- DEPTH, 4, in-flight prediction queue entries (power of two, >=2).
- FALLTHRU_OFFSET, 8, byte offset from branch PC to the not-taken path (includes delay slot).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Pred_push_IN  in  1  fetch pushes a prediction this cycle.
- Pred_PC_IN  in  32  branch PC.
- Pred_valid_IN  in  1  BTB hit, i.e. predicted taken.
- Pred_target_IN  in  32  predicted target (ignored when Pred_valid_IN=0).
- Full_OUT  out  1  queue full; fetch must stall branch issue.
- Resolve_IN  in  1  execute resolves the oldest branch this cycle.
- Actual_taken_IN  in  1  branch actually taken.
- Actual_target_IN  in  32  computed target.
- Resolution_OUT  out  1  BTB write strobe, one-cycle pulse.
- Branch_addr_OUT  out  32  PC to write into the BTB.
- Branch_resolved_addr_OUT  out  32  target to write into the BTB.
- Mispredict_OUT  out  1  redirect/flush pulse, one cycle.
- Redirect_addr_OUT  out  32  correct next PC, valid with Mispredict_OUT.
- Underflow_OUT  out  1  sticky error: Resolve_IN while empty.
- Branch_count_OUT  out  32  resolved branches.
- Mispredict_count_OUT  out  32  mispredicts.

Behaviour:
- Reset (async, RESET=0): queue empty; all outputs and counters 0; Full_OUT=0.
- Queue:
  - Circular buffer with pointers of log2(DEPTH) bits plus a count.
  - Full_OUT = (count==DEPTH), combinational from registered count.
  - A push while full is dropped and the entry not stored; the bench treats this as a protocol violation.
- Simultaneous push and resolve, non-empty queue: both occur, count unchanged. Push and resolve on an empty queue: the resolve underflows (Underflow_OUT set) and the push is stored.
- Resolve: pops the head entry and evaluates it. All outputs are registered, so they appear the cycle after Resolve_IN.
  - Correct prediction, no output pulse:
    - predicted taken, actually taken, target equal; or
    - predicted not-taken, actually not-taken.
  - Mispredict A (predicted not-taken, actually taken): Mispredict_OUT=1, Redirect=Actual_target. Resolution_OUT=1 with Branch_addr=PC and Branch_resolved_addr=Actual_target.
  - Mispredict B (predicted taken, target mismatch): same outputs as A.
  - Mispredict C (predicted taken, actually not-taken): Mispredict_OUT=1, Redirect=PC+FALLTHRU_OFFSET (mod 2^32), Resolution_OUT=0. The BTB has no invalidate.
  - Actual_target==0 while taken: Resolution_OUT suppressed, because the BTB treats 0 as no-write. Mispredict is still signalled.
  - Branch_count_OUT increments on every non-underflow resolve. Mispredict_count_OUT increments with each Mispredict_OUT. Both wrap at 2^32.
- Mispredict flush:
  - In the cycle Mispredict_OUT is registered, all entries younger than the resolved one are discarded (wrong path): count:=0, rd_ptr:=wr_ptr.
  - A push arriving in that same resolve cycle is also discarded.
  - Flush wins over push.
- Pulses: Resolution_OUT and Mispredict_OUT last exactly one cycle. Address outputs hold their last value otherwise.
- Underflow: Resolve_IN with count==0 sets Underflow_OUT, which stays 1 until reset. No pop, no counters, no pulses.
- Reset mid-operation: queue and all state cleared immediately. Pending pulses are cancelled.

Decomposition:
- Shared package btb_pkg:
  - ADDR_W=32 and the BTB index/tag split constants (index [11:2], tag [31:12]), shared with the BTB.
  - A prediction-entry struct {pc, valid, target}.
  - An outcome enum {CORRECT, MISS_NT_T, MISS_TGT, MISS_T_NT}.
- Sub-module pred_fifo: the circular queue with push/pop/flush and count. The compare/update/counter logic stays in btb_resolve_unit.

Test Plan:
- Push PC=0x100, pred_valid=0; resolve taken, target=0x200 -> next cycle Resolution=1, Branch_addr=0x100, resolved=0x200, Mispredict=1, Redirect=0x200, counts 1/1.
- Push PC=0x104, pred 0x300; resolve taken, 0x300 -> no pulses, Branch_count=1, Mispredict_count=0.
- Push PC=0x108, pred 0x400; resolve not-taken -> Mispredict=1, Redirect=0x110, Resolution=0.
- Push 4 entries (DEPTH=4) -> Full_OUT=1. Resolve the head as a mispredict with a simultaneous push -> queue empty, Full_OUT=0, the push dropped.
- Resolve with empty queue -> Underflow_OUT=1 and sticky, counters 0. Assert RESET=0 mid-cycle -> Underflow_OUT and all outputs 0 immediately.
- Push PC=0x10C, pred_valid=0; resolve taken, target=0x0 -> Mispredict=1, Redirect=0, Resolution=0.
